// File: rtl/parking_pkg.sv
// Shared types and beam-pattern table for the parking sensor emulator.
package parking_pkg;

    typedef enum logic [1:0] {
        CAR_IN  = 2'b00,
        CAR_OUT = 2'b01,
        PED_IN  = 2'b10,
        PED_OUT = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        P1,
        P2,
        P3,
        GAP
    } emu_state_t;

    // {sensor_a, sensor_b} per command type (row) and phase P1/P2/P3/GAP (column).
    localparam logic [1:0] BEAM_LUT [4][4] = '{
        '{2'b10, 2'b11, 2'b01, 2'b00},   // CAR_IN
        '{2'b01, 2'b11, 2'b10, 2'b00},   // CAR_OUT
        '{2'b10, 2'b00, 2'b01, 2'b00},   // PED_IN
        '{2'b01, 2'b00, 2'b10, 2'b00}    // PED_OUT
    };

    // Beam pattern for a given command in a given state; IDLE leaves both beams clear.
    function automatic logic [1:0] beam_pattern(input cmd_t cmd, input emu_state_t st);
        case (st)
            P1:      beam_pattern = BEAM_LUT[cmd][0];
            P2:      beam_pattern = BEAM_LUT[cmd][1];
            P3:      beam_pattern = BEAM_LUT[cmd][2];
            GAP:     beam_pattern = BEAM_LUT[cmd][3];
            default: beam_pattern = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one beam phase; expire is high while the count is zero.
module phase_timer #(
    parameter int  PHASE_CYCLES = 25_000_000,
    localparam int CNT_W        = $clog2(PHASE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PHASE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Reload on request, otherwise count down and rest at zero.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset)
            count <= '0;
        else if (load)
            count <= RELOAD;
        else if (count != '0)
            count <= count - CNT_W'(1);
    end

    assign expire = (count == '0);

endmodule

// File: rtl/parking_sensor_emulator.sv
// Transmit side of the two-beam parking sensor protocol: replays each accepted
// command as a timed P1/P2/P3/GAP beam sequence on sensor_a/sensor_b.
// Optional build macro SENSOR_EMU_REPEAT_EN adds cmd_count and back-to-back repeats.
module parking_sensor_emulator
    import parking_pkg::*;
#(
    parameter int PHASE_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
`ifdef SENSOR_EMU_REPEAT_EN
    input  logic [4:0] cmd_count,
`endif
    output logic       sensor_a,
    output logic       sensor_b,
    output logic       busy,
    output logic       done
);

    emu_state_t state, state_next;
    cmd_t       cmd_q, cmd_next;
    logic       accept, expire, load, done_next;
    logic [1:0] beam_q, beam_next;
`ifdef SENSOR_EMU_REPEAT_EN
    logic [4:0] remaining_q, remaining_next;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign sensor_a  = beam_q[1];
    assign sensor_b  = beam_q[0];

    phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .expire (expire)
    );

    // Next-state, command latch and phase-timer reload decisions.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_next = state;
        cmd_next   = cmd_q;
        load       = 1'b0;
        done_next  = 1'b0;
`ifdef SENSOR_EMU_REPEAT_EN
        remaining_next = remaining_q;
`endif
        case (state)
            IDLE: if (accept) begin
                state_next = P1;
                cmd_next   = cmd_t'(cmd_type);
                load       = 1'b1;
`ifdef SENSOR_EMU_REPEAT_EN
                remaining_next = (cmd_count == 5'd0) ? 5'd1 : cmd_count;
`endif
            end
            P1: if (expire) begin
                state_next = P2;
                load       = 1'b1;
            end
            P2: if (expire) begin
                state_next = P3;
                load       = 1'b1;
            end
            P3: if (expire) begin
                state_next = GAP;
                load       = 1'b1;
            end
            GAP: if (expire) begin
                load = 1'b1;
`ifdef SENSOR_EMU_REPEAT_EN
                if (remaining_q > 5'd1) begin
                    remaining_next = remaining_q - 5'd1;
                    state_next     = P1;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
`else
                state_next = IDLE;
                done_next  = 1'b1;
`endif
            end
            default: state_next = IDLE;
        endcase
        // Beams are decoded from the upcoming state so the registered outputs
        // line up with the state they belong to and never glitch between phases.
        beam_next = beam_pattern(cmd_next, state_next);
    end

    // State, latched command, registered beams and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cmd_q  <= CAR_IN;
            beam_q <= 2'b00;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            cmd_q  <= cmd_next;
            beam_q <= beam_next;
            done   <= done_next;
        end
    end

`ifdef SENSOR_EMU_REPEAT_EN
    // Remaining repetitions of the current command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            remaining_q <= 5'd0;
        else
            remaining_q <= remaining_next;
    end
`endif

endmodule

// File: tb/tb_parking_sensor_emulator.sv
// Self-checking bench for parking_sensor_emulator. Two instances (PHASE_CYCLES=2
// and PHASE_CYCLES=1) share stimulus; each has its own expected-cycle queue built
// from the protocol's beam table. Honours SENSOR_EMU_REPEAT_EN when defined.
module tb_parking_sensor_emulator;

    localparam int DEPTH = 1024;
    localparam logic [4:0] IDLE_ENT = 5'b00001;   // {a,b,busy,done,ready}
    localparam logic [4:0] DONE_ENT = 5'b00011;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_type;
`ifdef SENSOR_EMU_REPEAT_EN
    logic [4:0] cmd_count;
    int         ncnt = 1;
`endif
    logic a0, b0, busy0, done0, ready0;
    logic a1, b1, busy1, done1, ready1;

    wire [4:0] obs0 = {a0, b0, busy0, done0, ready0};
    wire [4:0] obs1 = {a1, b1, busy1, done1, ready1};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       nv = 1'b0;
    logic [1:0] nt = 2'b00;
    logic       nrst = 1'b0;
    logic [1:0] acc;

    string      pat [4];
    logic [4:0] ebuf [2][DEPTH];
    int         hd [2];
    int         tl [2];

    always #5 clk = ~clk;

    parking_sensor_emulator #(.PHASE_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready0),
        .cmd_type(cmd_type),
`ifdef SENSOR_EMU_REPEAT_EN
        .cmd_count(cmd_count),
`endif
        .sensor_a(a0), .sensor_b(b0), .busy(busy0), .done(done0)
    );

    parking_sensor_emulator #(.PHASE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready1),
        .cmd_type(cmd_type),
`ifdef SENSOR_EMU_REPEAT_EN
        .cmd_count(cmd_count),
`endif
        .sensor_a(a1), .sensor_b(b1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [4:0] e);
        ebuf[i][tl[i]] = e;
        tl[i] = (tl[i] + 1) % DEPTH;
    endtask

    // Expected cycles for one accepted command on instance i.
    task automatic push_cmd(input int i, input int t);
        int n;
        int ph;
        logic ba, bb;
        ph = (i == 0) ? 2 : 1;
        n  = 1;
`ifdef SENSOR_EMU_REPEAT_EN
        n = (ncnt == 0) ? 1 : ncnt;
`endif
        for (int r = 0; r < n; r++)
            for (int p = 0; p < 4; p++) begin
                ba = (pat[t][2*p]   == "1");
                bb = (pat[t][2*p+1] == "1");
                for (int c = 0; c < ph; c++)
                    push(i, {ba, bb, 3'b100});
            end
        push(i, DONE_ENT);
    endtask

    // One clock cycle: compare at the falling edge, then apply the next stimulus.
    task automatic step();
        logic [4:0] cur [2];
        logic [4:0] got;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cur[i] = (hd[i] == tl[i]) ? IDLE_ENT : ebuf[i][hd[i]];
            got    = (i == 0) ? obs0 : obs1;
            check($sformatf("dut%0d_cyc%0d", i, cyc), {27'd0, got}, {27'd0, cur[i]});
            if (hd[i] != tl[i]) hd[i] = (hd[i] + 1) % DEPTH;
        end
        cyc++;
        acc       = 2'b00;
        reset     = nrst;
        cmd_valid = nv;
        cmd_type  = nt;
`ifdef SENSOR_EMU_REPEAT_EN
        cmd_count = 5'(ncnt);
`endif
        if (nrst) begin
            #1;
            check($sformatf("rst_now0_cyc%0d", cyc), {27'd0, obs0}, {27'd0, IDLE_ENT});
            check($sformatf("rst_now1_cyc%0d", cyc), {27'd0, obs1}, {27'd0, IDLE_ENT});
            hd[0] = tl[0];
            hd[1] = tl[1];
        end else begin
            for (int i = 0; i < 2; i++)
                if (nv && cur[i][0]) begin
                    acc[i] = 1'b1;
                    push_cmd(i, int'(nt));
                end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got_b2b;
        pat[0] = "10110100";   // car enter
        pat[1] = "01111000";   // car exit
        pat[2] = "10000100";   // pedestrian enter
        pat[3] = "01001000";   // pedestrian exit
        hd[0] = 0; tl[0] = 0; hd[1] = 0; tl[1] = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
`ifdef SENSOR_EMU_REPEAT_EN
        cmd_count = 5'd1;
`endif
        #1;
        check("reset_state0", {27'd0, obs0}, {27'd0, IDLE_ENT});
        check("reset_state1", {27'd0, obs1}, {27'd0, IDLE_ENT});

        // Car enter, then pedestrian exit, each followed by idle time.
        nv = 1'b1; nt = 2'b00; step();
        nv = 1'b0; repeat (12) step();
        nv = 1'b1; nt = 2'b11; step();
        nv = 1'b0; repeat (10) step();

        // Car exit, then car enter held valid until accepted in the done cycle.
        nv = 1'b1; nt = 2'b01; step();
        nt = 2'b00;
        got_b2b = 1'b0;
        for (int k = 0; k < 20 && !got_b2b; k++) begin
            step();
            if (acc[0]) got_b2b = 1'b1;
        end
        nv = 1'b0;
        check("b2b_accept", {31'd0, got_b2b}, 32'd1);
        repeat (12) step();

        // Reset during P2 of car enter, then a pedestrian enter.
        nv = 1'b1; nt = 2'b00; step();
        nv = 1'b0; repeat (2) step();
        nrst = 1'b1; step();
        nrst = 1'b0;
        nv = 1'b1; nt = 2'b10; step();
        nv = 1'b0; repeat (12) step();

`ifdef SENSOR_EMU_REPEAT_EN
        // Sixteen contiguous car-enter sequences.
        ncnt = 16;
        nv = 1'b1; nt = 2'b00; step();
        nv = 1'b0; ncnt = 1;
        repeat (140) step();
`endif

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            nv   = 1'($urandom_range(0, 1));
            nt   = 2'($urandom_range(0, 3));
            nrst = ($urandom_range(0, 299) == 0);
`ifdef SENSOR_EMU_REPEAT_EN
            ncnt = ($urandom_range(0, 19) == 0) ? 16 : int'($urandom_range(0, 3));
`endif
            step();
        end
        nrst = 1'b0;
        nv   = 1'b0;
        repeat (150) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_sensor_emulator.md
Name: parking_sensor_emulator

Overview:
- Transmit side of the two-beam parking-lot sensor protocol: generates sensor_a / sensor_b waveforms for car and pedestrian entry/exit events.
- Commands arrive on a valid/ready interface; each is replayed as a timed four-phase beam sequence.
- Drives the occupancy counter's sensor inputs for on-board self-test and demo.
- Replaces the hand-toggled inputs in benches.

Parameters:
- PHASE_CYCLES, 25_000_000: clock cycles each phase is held (0.5 s at 50 MHz). Must be >= 1.
- CNT_W, $clog2(PHASE_CYCLES+1): phase counter width; derived, not overridden.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted on valid&&ready
- cmd_type  in  2  00 car enter, 01 car exit, 10 pedestrian enter, 11 pedestrian exit
- cmd_count  in  5  repeat count (only with SENSOR_EMU_REPEAT_EN)
- sensor_a  out  1  outer beam, 1 = blocked
- sensor_b  out  1  inner beam, 1 = blocked
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, active-high): state IDLE; sensor_a=0, sensor_b=0, busy=0, done=0, cmd_ready=1.
- Reset mid-sequence: beams drop to 00 immediately, the command is discarded, and no done pulse is issued.
- FSM states: IDLE, P1, P2, P3, GAP. cmd_ready = (state==IDLE). busy = (state!=IDLE).
- Command accept: on the edge where cmd_valid&&cmd_ready, cmd_type is latched. The next cycle is P1 with the phase counter loaded with PHASE_CYCLES-1.
- Beam patterns {a,b} per phase P1/P2/P3/GAP:
  - car enter: 10/11/01/00
  - car exit: 01/11/10/00
  - pedestrian enter: 10/00/01/00
  - pedestrian exit: 01/00/10/00
- Sensor outputs are registered and decoded from state plus the latched type only; they must not glitch between phases.
- Each phase lasts exactly PHASE_CYCLES cycles. Total sequence length is 4*PHASE_CYCLES cycles.
- Counter behaviour: decrements every cycle. At 0, advance to the next state and reload. P1->P2->P3->GAP->IDLE.
- Completion: GAP expiry -> IDLE, with done=1 for exactly that first IDLE cycle. cmd_ready is also 1 in that cycle, so a back-to-back accept is legal. The next P1 starts one cycle after done; beams stay 00 during that cycle.
- cmd_type changes while busy are ignored.
- cmd_valid held high while busy is not lost: it waits for ready.
- PHASE_CYCLES=1: every state lasts one cycle; the counter is always 0.

Optional Feature:
- Macro: SENSOR_EMU_REPEAT_EN.
- Defined:
  - The cmd_count port exists and is latched at accept; 0 is treated as 1.
  - A 5-bit remaining register is kept. On GAP expiry with remaining>1: decrement and go directly to P1 with no IDLE cycle and no done.
  - done pulses only after the final repetition; busy stays high throughout.
- Undefined:
  - The port is absent and every command plays exactly once.

Decomposition:
- Shared package parking_pkg:
  - cmd_t enum (CAR_IN, CAR_OUT, PED_IN, PED_OUT)
  - emu_state_t enum
  - 2-bit beam pattern constants per type/phase, as a constant lookup array indexed [cmd_t][phase]
- One sub-module, phase_timer: loadable down-counter with parameter PHASE_CYCLES, inputs load, output expire (count==0). Instantiated once.

Test Plan (PHASE_CYCLES=2 unless noted):
- Reset then a car-enter command accepted at cycle 0 -> {a,b} = 10,10,11,11,01,01,00,00 over cycles 1-8; done=1 at cycle 9 only; busy high cycles 1-8.
- Pedestrian exit -> 01,01,00,00,10,10,00,00; b never high while a is high.
- Back-to-back: car exit, then car enter with cmd_valid held high -> second accepted in the done cycle; car-enter P1 starts at cycle 10; exactly 2 done pulses.
- Reset asserted during P2 of car enter -> same-cycle a=b=0, cmd_ready=1, no done; a subsequent ped enter plays normally.
- PHASE_CYCLES=1, car enter -> 10,11,01,00 on consecutive cycles; done on the 5th cycle after accept.
- SENSOR_EMU_REPEAT_EN, cmd_count=16, car enter -> 16 contiguous sequences (128 cycles), single done at cycle 129, cmd_ready low throughout.
